wb_commit: RTL and testbench
============================

// Module: wb_commit
// PURPOSE
//  Writeback/commit unit of the RV32I pipeline: sole writer of the register file write port.
//  Merges single-cycle execute results with variable-latency load responses, aligns and
//  sign-extends load data, tracks outstanding load destinations (scoreboard) and stalls
//  execute on port conflict or WAW against a pending load.
// PARAMETERS
//  LD_DEPTH  2  max outstanding loads (pending-load FIFO entries, >=1)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  ex_valid    in   1   execute result offered
//  ex_rd       in   5   execute destination register
//  ex_data     in   32  execute result
//  ex_ready    out  1   execute result accepted this cycle (comb)
//  ld_valid    in   1   load issued to memory this cycle
//  ld_rd       in   5   load destination register
//  ld_funct3   in   3   load type (000 LB,001 LH,010 LW,100 LBU,101 LHU)
//  ld_addr_lo  in   2   load byte address [1:0]
//  ld_ready    out  1   FIFO can take a load (comb, = count<LD_DEPTH)
//  mem_rvalid  in   1   load response valid (no backpressure)
//  mem_rdata   in   32  load response word (aligned word)
//  rf_we       out  1   register file write enable (registered)
//  rf_rd       out  5   register file write address (registered)
//  rf_wd       out  32  register file write data (registered)
//  pend        out  32  bit r set while any FIFO entry targets r; bit0 always 0
//  err_orphan  out  1   sticky: response arrived with FIFO empty
// BEHAVIOUR
//  Reset (async, rst_n=0): rf_we=0, rf_rd=0, rf_wd=0, err_orphan=0, FIFO empty, pend=0.
//   Reset mid-operation discards all pending loads; later responses count as orphans.
//  Pending-load FIFO: push on ld_valid&&ld_ready storing {rd,funct3,addr_lo}; pop on
//   mem_rvalid with FIFO non-empty; responses return in issue order. Push+pop same cycle
//   legal when not full; count unchanged. ld_valid while full is ignored (no push).
//   Response in same cycle as push to empty FIFO is an orphan (needs >=1 cycle latency).
//  pend: OR of decoded rd over valid entries (derived from registered state, no comb path
//   from inputs); rd=0 entries contribute nothing.
//  ex_ready = !mem_rvalid && !(ex_rd!=0 && pend[ex_rd]). Load response always wins the
//   port; execute holds ex_* stable until accepted.
//  Latency: accepted ex result or popped response in cycle N -> rf_we=1 in N+1 with data;
//   rf_we=0 in any cycle following no acceptance. Target rd=0: consumed, rf_we stays 0.
//  Load data (from popped entry): LB/LBU byte mem_rdata[8*a+7:8*a], a=addr_lo; LH/LHU
//   half selected by addr_lo[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW and any
//   other funct3 write the raw word. Misaligned addr_lo ignored beyond bits used.
//  Orphan response (FIFO empty): dropped, no write, err_orphan set until reset.
//  rf_* are the only in-flight write; hazard/bypass logic uses rf_* the cycle rf_we=1.
// TESTING
//  1. ex_valid, rd=5, data=0x1234 -> ex_ready=1; next cycle rf_we=1, rf_rd=5, rf_wd=0x1234.
//  2. LB rd=3 addr_lo=2, resp 0x0080FF00 -> pend[3]=1 until pop; rf_wd=0xFFFFFF80. LHU
//     addr_lo=2 same word -> rf_wd=0x00000080.
//  3. Load rd=7 pending, ex_valid rd=7 -> ex_ready=0 until response; load written first,
//     ex result written the cycle after (ordering 7<-load then 7<-ex).
//  4. mem_rvalid and ex_valid(rd=9) same cycle -> ex_ready=0, load written; ex next cycle.
//  5. Fill LD_DEPTH=2 loads -> ld_ready=0, third ld_valid ignored; response+issue same
//     cycle when count=1 -> count stays 1, in-order writes verified.
//  6. mem_rvalid with FIFO empty -> no rf_we, err_orphan=1; rst_n pulse mid-load with 2
//     pending -> pend=0, rf_we=0, err_orphan=0 immediately (async).

Source files
------------

// File: rtl/wb_commit_if.sv
// Writeback/commit bundle: execute results, load issue, memory response and the
// register-file write port with load scoreboard status.
interface wb_commit_if;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ld_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] pend;
  logic        err_orphan;

  modport master (
    output ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_funct3, ld_addr_lo,
           mem_rvalid, mem_rdata,
    input  ex_ready, ld_ready, rf_we, rf_rd, rf_wd, pend, err_orphan
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_funct3, ld_addr_lo,
           mem_rvalid, mem_rdata,
    output ex_ready, ld_ready, rf_we, rf_rd, rf_wd, pend, err_orphan
  );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit unit: sole register-file writer, merging execute results with
// in-order load responses, with a pending-load scoreboard for hazard stalls.
module wb_commit #(
  parameter int LD_DEPTH = 2
) (
  input logic        clk,
  input logic        rst_n,
  wb_commit_if.slave bus
);
  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = $clog2(LD_DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } ld_entry_t;

  ld_entry_t           slot_q [LD_DEPTH];
  logic [LD_DEPTH-1:0] slot_vld_q;
  ptr_t                wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;

  logic        rf_we_q;
  logic [4:0]  rf_rd_q;
  logic [31:0] rf_wd_q;
  logic        err_orphan_q;

  logic        push, pop, orphan, ex_accept;
  logic [31:0] pend_c;
  ld_entry_t   head;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(LD_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                             input logic [1:0]  a,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Scoreboard view comes only from registered slot state, never from this cycle's inputs.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pend_c = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (slot_vld_q[i]) pend_c[slot_q[i].rd] = 1'b1;
    end
    pend_c[0] = 1'b0;
  end

  assign head        = slot_q[rd_ptr_q];
  assign bus.ld_ready = (count_q < CW'(LD_DEPTH));
  assign push        = bus.ld_valid && bus.ld_ready;
  assign pop         = bus.mem_rvalid && (count_q != '0);
  assign orphan      = bus.mem_rvalid && (count_q == '0);
  assign bus.ex_ready = !bus.mem_rvalid && !((bus.ex_rd != 5'd0) && pend_c[bus.ex_rd]);
  assign ex_accept   = bus.ex_valid && bus.ex_ready;

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      slot_vld_q <= '0;
    end else begin
      if (push) begin
        slot_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        slot_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q             <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: slot payload is not reset; validity lives in slot_vld_q, which is.
  always_ff @(posedge clk) begin
    if (push) slot_q[wr_ptr_q] <= '{rd: bus.ld_rd, funct3: bus.ld_funct3,
                                    addr_lo: bus.ld_addr_lo};
  end

  // A load response always owns the port; execute only writes when it was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wd_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      if (pop) begin
        rf_we_q <= (head.rd != 5'd0);
        rf_rd_q <= head.rd;
        rf_wd_q <= align_load(head.funct3, head.addr_lo, bus.mem_rdata);
      end else if (ex_accept) begin
        rf_we_q <= (bus.ex_rd != 5'd0);
        rf_rd_q <= bus.ex_rd;
        rf_wd_q <= bus.ex_data;
      end
      if (orphan) err_orphan_q <= 1'b1;
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wd      = rf_wd_q;
  assign bus.pend       = pend_c;
  assign bus.err_orphan = err_orphan_q;
endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: a cycle-by-cycle vector table plus hand-written
// reset and orphan sequences.
module tb_wb_commit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_commit_if bus ();

  wb_commit #(.LD_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_a;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        e_ex_ready;
    logic        e_ld_ready;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
    logic        e_orphan;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vecs[$];

  function automatic vec_t mk(
    input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
    input logic ldv, input logic [4:0] ldrd, input logic [2:0] f3, input logic [1:0] a,
    input logic mv, input logic [31:0] md,
    input logic eexr, input logic eldr, input logic ewe, input logic [4:0] erd,
    input logic [31:0] ewd, input logic [31:0] epend, input logic eorph);
    vec_t v;
    v.ex_valid = exv;  v.ex_rd = exrd;  v.ex_data = exd;
    v.ld_valid = ldv;  v.ld_rd = ldrd;  v.ld_f3 = f3;  v.ld_a = a;
    v.mem_rvalid = mv; v.mem_rdata = md;
    v.e_ex_ready = eexr; v.e_ld_ready = eldr; v.e_we = ewe; v.e_rd = erd;
    v.e_wd = ewd; v.e_pend = epend; v.e_orphan = eorph;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.ex_valid   = v.ex_valid;
    bus.ex_rd      = v.ex_rd;
    bus.ex_data    = v.ex_data;
    bus.ld_valid   = v.ld_valid;
    bus.ld_rd      = v.ld_rd;
    bus.ld_funct3  = v.ld_f3;
    bus.ld_addr_lo = v.ld_a;
    bus.mem_rvalid = v.mem_rvalid;
    bus.mem_rdata  = v.mem_rdata;
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check({tag, " ex_ready"}, 32'(bus.ex_ready), 32'(v.e_ex_ready));
    check({tag, " ld_ready"}, 32'(bus.ld_ready), 32'(v.e_ld_ready));
    @(posedge clk);
    #1;
    check({tag, " rf_we"}, 32'(bus.rf_we), 32'(v.e_we));
    if (v.e_we) begin
      check({tag, " rf_rd"}, 32'(bus.rf_rd), 32'(v.e_rd));
      check({tag, " rf_wd"}, bus.rf_wd, v.e_wd);
    end
    check({tag, " pend"}, bus.pend, v.e_pend);
    check({tag, " err_orphan"}, 32'(bus.err_orphan), 32'(v.e_orphan));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            exv rd  data          ldv rd  f3    a    mv  rdata          exr ldr we rd  wd            pend          orph
    vecs.push_back(mk(1, 5, 32'h0000_1234, 0, 0, 3'd0, 2'd0, 0, 32'h0,         1, 1, 1, 5, 32'h0000_1234, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 3'd0, 2'd0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 3, 3'd0, 2'd2, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0000_0008, 0));
    vecs.push_back(mk(0, 3, 32'h0,         0, 0, 3'd0, 2'd0, 0, 32'h0,         0, 1, 0, 0, 32'h0,         32'h0000_0008, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 3'd0, 2'd0, 1, 32'h0080_FF00, 0, 1, 1, 3, 32'hFFFF_FF80, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 4, 3'd5, 2'd2, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0000_0010, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 3'd0, 2'd0, 1, 32'h0080_FF00, 0, 1, 1, 4, 32'h0000_0080, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 7, 3'd2, 2'd0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0000_0080, 0));
    vecs.push_back(mk(1, 7, 32'h0000_0077, 0, 0, 3'd0, 2'd0, 0, 32'h0,         0, 1, 0, 0, 32'h0,         32'h0000_0080, 0));
    vecs.push_back(mk(1, 7, 32'h0000_0077, 0, 0, 3'd0, 2'd0, 1, 32'hDEAD_BEEF, 0, 1, 1, 7, 32'hDEAD_BEEF, 32'h0,         0));
    vecs.push_back(mk(1, 7, 32'h0000_0077, 0, 0, 3'd0, 2'd0, 0, 32'h0,         1, 1, 1, 7, 32'h0000_0077, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 8, 3'd2, 2'd0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0000_0100, 0));
    vecs.push_back(mk(1, 9, 32'h0000_0099, 0, 0, 3'd0, 2'd0, 1, 32'h1122_3344, 0, 1, 1, 8, 32'h1122_3344, 32'h0,         0));
    vecs.push_back(mk(1, 9, 32'h0000_0099, 0, 0, 3'd0, 2'd0, 0, 32'h0,         1, 1, 1, 9, 32'h0000_0099, 32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 10, 3'd2, 2'd0, 0, 32'h0,        1, 1, 0, 0, 32'h0,         32'h0000_0400, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 11, 3'd0, 2'd1, 0, 32'h0,        1, 1, 0, 0, 32'h0,         32'h0000_0C00, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 12, 3'd2, 2'd0, 0, 32'h0,        1, 0, 0, 0, 32'h0,         32'h0000_0C00, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 3'd0, 2'd0, 1, 32'h0000_00AB, 0, 0, 1, 10, 32'h0000_00AB, 32'h0000_0800, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 13, 3'd1, 2'd0, 1, 32'h0000_7F00, 0, 1, 1, 11, 32'h0000_007F, 32'h0000_2000, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 3'd0, 2'd0, 1, 32'h1234_8001, 0, 1, 1, 13, 32'hFFFF_8001, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 3'd2, 2'd0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 3'd0, 2'd0, 1, 32'hFFFF_FFFF, 0, 1, 0, 0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 32'h0000_0005, 0, 0, 3'd0, 2'd0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 3'd0, 2'd0, 1, 32'h0000_0042, 0, 1, 0, 0, 32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 3'd0, 2'd0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         1));

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset rf_we", 32'(bus.rf_we), 32'h0);
    check("reset rf_rd", 32'(bus.rf_rd), 32'h0);
    check("reset rf_wd", bus.rf_wd, 32'h0);
    check("reset pend", bus.pend, 32'h0);
    check("reset err_orphan", 32'(bus.err_orphan), 32'h0);
    check("reset ld_ready", 32'(bus.ld_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Async reset with two loads pending and a write in flight.
    apply("pre_rst0", mk(0, 0, 32'h0, 1, 20, 3'd2, 2'd0, 0, 32'h0,
                         1, 1, 0, 0, 32'h0, 32'h0010_0000, 1));
    apply("pre_rst1", mk(1, 22, 32'h0000_005A, 1, 21, 3'd2, 2'd0, 0, 32'h0,
                         1, 1, 1, 22, 32'h0000_005A, 32'h0030_0000, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst pend", bus.pend, 32'h0);
    check("midrst rf_we", 32'(bus.rf_we), 32'h0);
    check("midrst err_orphan", 32'(bus.err_orphan), 32'h0);
    check("midrst ld_ready", 32'(bus.ld_ready), 32'h1);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Response for a load discarded by reset is an orphan.
    apply("post_rst_resp", mk(0, 0, 32'h0, 0, 0, 3'd0, 2'd0, 1, 32'h0000_0055,
                              0, 1, 0, 0, 32'h0, 32'h0, 1));

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2 err_orphan", 32'(bus.err_orphan), 32'h0);
    #1;
    rst_n = 1'b1;

    // Response in the same cycle as a push to an empty FIFO is an orphan.
    apply("push_resp_empty", mk(0, 0, 32'h0, 1, 6, 3'd2, 2'd0, 1, 32'h0000_0066,
                                0, 1, 0, 0, 32'h0, 32'h0000_0040, 1));
    apply("late_resp", mk(0, 0, 32'h0, 0, 0, 3'd0, 2'd0, 1, 32'h0000_0077,
                          0, 1, 1, 6, 32'h0000_0077, 32'h0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
